rs_mult_station: RTL and testbench
==================================

# rs_mult_station

Parametrised reservation station for the Tomasulo multiplier path. Holds up to `NUM_ENTRIES` issued multiply ops, snoops the CDB to capture pending operands, and dispatches the oldest ready entry to the multiplier over a valid/ready handshake. Sits between the issue stage and the register file tag lookup on one side, and the multiplier functional unit on the other.

## Interface
- `NUM_ENTRIES`, 3: station depth (2..16).
- `DATA_W`, 16: operand/CDB data width.
- `TAG_W`, 4: producer tag width; tag 0 means "no producer, value valid".
- `BASE_TAG`, 1: tag of entry 0; entry i owns tag `BASE_TAG+i`; `BASE_TAG>=1`, `BASE_TAG+NUM_ENTRIES-1 < 2**TAG_W`.
- `OP_W`, 2: opcode width.
- `Clock` in 1: single clock, rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of all entries.
- `iss_valid` in 1: issue request.
- `iss_ready` out 1: a free entry exists.
- `iss_op` in OP_W: operation.
- `iss_vj`, `iss_vk` in DATA_W: operand values (meaningful when matching Q is 0).
- `iss_qj`, `iss_qk` in TAG_W: producer tags.
- `iss_tag` out TAG_W: tag allocated to the accepted issue (rename target).
- `cdb_valid` in 1: CDB broadcast.
- `cdb_tag` in TAG_W, `cdb_data` in DATA_W: broadcast tag/value.
- `fu_valid` out 1: dispatch request.
- `fu_ready` in 1: multiplier accepts.
- `fu_op` out OP_W, `fu_a`, `fu_b` out DATA_W, `fu_tag` out TAG_W: dispatched op, Vj, Vk, owning tag.
- `occupancy` out clog2(NUM_ENTRIES+1): busy entry count.

## Operation
- Per entry: Busy, Op, Vj, Vk, Qj, Qk. Entry ready = Busy & Qj==0 & Qk==0.
- Issue: on `iss_valid & iss_ready`, lowest-index free entry is written, Busy set; `iss_tag` = its tag (combinational from free vector, valid whenever `iss_ready`).
- Issue-time bypass: if `cdb_valid` and `cdb_tag` equals nonzero `iss_qj`/`iss_qk` in the same cycle, the CDB value is written into V and Q cleared.
- Wakeup: every busy entry with Qj (Qk) == `cdb_tag` on `cdb_valid` captures `cdb_data` into Vj (Vk) and clears Qj (Qk). A CDB tag of 0 never matches.
- Age: NUM_ENTRIES×NUM_ENTRIES age matrix; on allocation the new entry is marked younger than all busy entries. Selection = the ready entry older than all other ready entries.
- Dispatch: `fu_valid` = any ready entry, or a locked selection. When `fu_valid & !fu_ready`, selection is locked; `fu_*` outputs hold stable until accepted, even if an older entry becomes ready. On `fu_valid & fu_ready` the selected entry's Busy clears and the lock releases.
- Flush: clears all Busy, lock and age matrix; takes priority over issue, wakeup and dispatch in that cycle.

## Timing
- Reset (async, `Resetn`=0): all Busy=0, lock=0, `fu_valid`=0, `occupancy`=0, `iss_ready`=1, `iss_tag`=`BASE_TAG`, `fu_op`/`fu_a`/`fu_b`/`fu_tag`=0. Reset mid-operation discards all entries; no dispatch follows.
- `fu_*` and `iss_ready` depend only on registered state; no combinational path from `iss_*`/`cdb_*` to `fu_*`.
- Issue with both operands ready at edge k: `fu_valid` earliest in cycle k+1.
- CDB wakeup at edge k (or bypass at issue): entry eligible in cycle k+1; never same-cycle dispatch.
- Full: `iss_ready`=0; a dispatch freeing an entry at edge k makes `iss_ready`=1 in cycle k+1 (no same-cycle reuse).
- Simultaneous issue and dispatch: both occur; `occupancy` unchanged.
- CDB tag equal to an entry's own tag does not affect that entry.

## Structure
- Shared package `tomasulo_pkg`: `TAG_NONE`=0, multiplier opcode constants (MUL, MULH, MULHU, DIV), default widths. Tag map per station defined there.
- Sub-module `rs_age_matrix`: allocate-vector, free-vector, ready-vector in, one-hot oldest-ready out.

## Test plan
- Reset, issue MUL Vj=3 Vk=5 Q=0 -> `iss_tag`=1; next cycle `fu_valid`=1, `fu_a`=3, `fu_b`=5, `fu_tag`=1; accept -> `occupancy`=0.
- Issue Qj=7; later CDB tag 7 data 0x00A0 -> entry dispatches next cycle with `fu_a`=0x00A0; issue with Qk=7 in the CDB-7 cycle -> bypass, Vk=CDB data.
- Fill 3 entries with `fu_ready`=0 -> `iss_ready`=0; accept one -> `iss_ready`=1 next cycle, reissue gets freed tag.
- Entries A(tag1, waiting), B(tag2, ready) with `fu_ready`=0: `fu_tag`=2 locked; wake A -> `fu_tag` stays 2 until accepted, then 1.
- Oldest-first: issue into entries 2 then 0 (both waiting), wake both same cycle -> entry 2 dispatches first.
- `flush` or `Resetn` low with 3 busy entries -> `occupancy`=0, `fu_valid`=0, no later dispatch.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: tag encoding, multiplier opcodes, default widths and station tag map.
// Pure constants; no timing or flow-control behaviour.
package tomasulo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAG_W  = 4;
    localparam int DEF_OP_W   = 2;

    // Tag 0 marks an operand whose value is already present.
    localparam int TAG_NONE = 0;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_MUL   = 2'd0,
        OP_MULH  = 2'd1,
        OP_MULHU = 2'd2,
        OP_DIV   = 2'd3
    } mul_op_e;

    // Each station owns a contiguous tag range starting at its base tag.
    localparam int MULT_RS_ENTRIES  = 3;
    localparam int MULT_RS_BASE_TAG = 1;
    localparam int ALU_RS_BASE_TAG  = MULT_RS_BASE_TAG + MULT_RS_ENTRIES;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for N station entries; returns the one-hot oldest ready entry combinationally.
// Matrix updates one cycle after alloc/free; no flow control of its own.
module rs_age_matrix
    import tomasulo_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic [N-1:0] i_alloc,
    input  logic [N-1:0] i_free,
    input  logic [N-1:0] i_ready,
    output logic [N-1:0] o_oldest
);

    // r_older[i][j] set means entry i is older than entry j.
    logic [N-1:0][N-1:0] r_older;
    logic [N-1:0]        w_blocked;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_older <= '0;
        end else if (i_flush) begin
            r_older <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i == j || i_alloc[i] || i_free[i]) begin
                        r_older[i][j] <= 1'b0;
                    end else if (i_alloc[j]) begin
                        r_older[i][j] <= 1'b1;
                    end else if (i_free[j]) begin
                        r_older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j != i && i_ready[j] && r_older[j][i]) begin
                    w_blocked[i] = 1'b1;
                end
            end
        end
    end

    assign o_oldest = i_ready & ~w_blocked;

endmodule

// File: rtl/rs_mult_station.sv
// Multiplier reservation station: issue with CDB bypass, CDB wakeup, oldest-ready dispatch.
// Dispatch earliest one cycle after an entry becomes ready; fu_* locked while fu_ready is low.
module rs_mult_station
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENTRIES = MULT_RS_ENTRIES,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TAG_W       = DEF_TAG_W,
    parameter int BASE_TAG    = MULT_RS_BASE_TAG,
    parameter int OP_W        = DEF_OP_W
) (
    input  logic                               Clock,
    input  logic                               Resetn,
    input  logic                               flush,
    input  logic                               iss_valid,
    output logic                               iss_ready,
    input  logic [OP_W-1:0]                    iss_op,
    input  logic [DATA_W-1:0]                  iss_vj,
    input  logic [DATA_W-1:0]                  iss_vk,
    input  logic [TAG_W-1:0]                   iss_qj,
    input  logic [TAG_W-1:0]                   iss_qk,
    output logic [TAG_W-1:0]                   iss_tag,
    input  logic                               cdb_valid,
    input  logic [TAG_W-1:0]                   cdb_tag,
    input  logic [DATA_W-1:0]                  cdb_data,
    output logic                               fu_valid,
    input  logic                               fu_ready,
    output logic [OP_W-1:0]                    fu_op,
    output logic [DATA_W-1:0]                  fu_a,
    output logic [DATA_W-1:0]                  fu_b,
    output logic [TAG_W-1:0]                   fu_tag,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = $clog2(NUM_ENTRIES + 1);
    localparam logic [TAG_W-1:0] TAG_ZERO = TAG_W'(TAG_NONE);

    logic [NUM_ENTRIES-1:0] r_busy;
    logic [OP_W-1:0]        r_op [NUM_ENTRIES];
    logic [DATA_W-1:0]      r_vj [NUM_ENTRIES];
    logic [DATA_W-1:0]      r_vk [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_qj [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_qk [NUM_ENTRIES];
    logic                   r_lock;
    logic [IDX_W-1:0]       r_lock_idx;

    logic [NUM_ENTRIES-1:0] w_ready;
    logic [NUM_ENTRIES-1:0] w_wake_j;
    logic [NUM_ENTRIES-1:0] w_wake_k;
    logic [NUM_ENTRIES-1:0] w_alloc;
    logic [NUM_ENTRIES-1:0] w_oldest;
    logic [NUM_ENTRIES-1:0] w_disp_vec;
    logic [IDX_W-1:0]       w_free_idx;
    logic [IDX_W-1:0]       w_oldest_idx;
    logic [IDX_W-1:0]       w_sel_idx;
    logic                   w_accept;
    logic                   w_disp;
    logic                   w_cdb_hit;
    logic                   w_byp_j;
    logic                   w_byp_k;

    assign w_cdb_hit = cdb_valid && (cdb_tag != TAG_ZERO);

    // An entry never reacts to a broadcast of its own tag.
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        localparam logic [TAG_W-1:0] OWN_TAG = TAG_W'(BASE_TAG + g);
        assign w_ready[g]  = r_busy[g] && (r_qj[g] == TAG_ZERO) && (r_qk[g] == TAG_ZERO);
        assign w_wake_j[g] = w_cdb_hit && r_busy[g] && (cdb_tag != OWN_TAG) && (r_qj[g] == cdb_tag);
        assign w_wake_k[g] = w_cdb_hit && r_busy[g] && (cdb_tag != OWN_TAG) && (r_qk[g] == cdb_tag);
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_oldest_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_oldest[i]) w_oldest_idx = IDX_W'(i);
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occupancy = occupancy + OCC_W'(r_busy[i]);
        end
    end

    rs_age_matrix #(
        .N (NUM_ENTRIES)
    ) u_age (
        .i_clk    (Clock),
        .i_rst_n  (Resetn),
        .i_flush  (flush),
        .i_alloc  (w_alloc),
        .i_free   (w_disp_vec),
        .i_ready  (w_ready),
        .o_oldest (w_oldest)
    );

    assign iss_ready = ~&r_busy;
    assign iss_tag   = TAG_W'(BASE_TAG) + TAG_W'(w_free_idx);
    assign w_accept  = iss_valid && iss_ready;
    assign w_alloc   = w_accept ? (NUM_ENTRIES'(1) << w_free_idx) : '0;
    assign w_byp_j   = w_cdb_hit && (iss_qj == cdb_tag);
    assign w_byp_k   = w_cdb_hit && (iss_qk == cdb_tag);

    // A stalled selection stays locked so the FU sees stable operands.
    assign w_sel_idx  = r_lock ? r_lock_idx : w_oldest_idx;
    assign fu_valid   = r_lock || (|w_ready);
    assign w_disp     = fu_valid && fu_ready;
    assign w_disp_vec = w_disp ? (NUM_ENTRIES'(1) << w_sel_idx) : '0;
    assign fu_op      = fu_valid ? r_op[w_sel_idx] : '0;
    assign fu_a       = fu_valid ? r_vj[w_sel_idx] : '0;
    assign fu_b       = fu_valid ? r_vk[w_sel_idx] : '0;
    assign fu_tag     = fu_valid ? (TAG_W'(BASE_TAG) + TAG_W'(w_sel_idx)) : '0;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_busy     <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_op[i] <= '0;
                r_vj[i] <= '0;
                r_vk[i] <= '0;
                r_qj[i] <= '0;
                r_qk[i] <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
            r_lock <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_alloc[i]) begin
                    r_busy[i] <= 1'b1;
                    r_op[i]   <= iss_op;
                    r_vj[i]   <= w_byp_j ? cdb_data : iss_vj;
                    r_qj[i]   <= w_byp_j ? TAG_ZERO : iss_qj;
                    r_vk[i]   <= w_byp_k ? cdb_data : iss_vk;
                    r_qk[i]   <= w_byp_k ? TAG_ZERO : iss_qk;
                end else begin
                    if (w_disp_vec[i]) r_busy[i] <= 1'b0;
                    if (w_wake_j[i]) begin
                        r_vj[i] <= cdb_data;
                        r_qj[i] <= TAG_ZERO;
                    end
                    if (w_wake_k[i]) begin
                        r_vk[i] <= cdb_data;
                        r_qk[i] <= TAG_ZERO;
                    end
                end
            end
            if (w_disp) begin
                r_lock <= 1'b0;
            end else if (fu_valid) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_rs_mult_station.sv
// Bench for rs_mult_station: directed vector table, hand-written corner sequences,
// and randomized traffic against an entry-list reference model.
module tb_rs_mult_station;

    localparam int N    = 3;
    localparam int DW   = 16;
    localparam int TW   = 4;
    localparam int BT   = 1;
    localparam int OW   = 2;
    localparam int OCCW = $clog2(N + 1);

    logic            Clock     = 1'b0;
    logic            Resetn    = 1'b0;
    logic            flush     = 1'b0;
    logic            iss_valid = 1'b0;
    logic            iss_ready;
    logic [OW-1:0]   iss_op    = '0;
    logic [DW-1:0]   iss_vj    = '0;
    logic [DW-1:0]   iss_vk    = '0;
    logic [TW-1:0]   iss_qj    = '0;
    logic [TW-1:0]   iss_qk    = '0;
    logic [TW-1:0]   iss_tag;
    logic            cdb_valid = 1'b0;
    logic [TW-1:0]   cdb_tag   = '0;
    logic [DW-1:0]   cdb_data  = '0;
    logic            fu_valid;
    logic            fu_ready  = 1'b0;
    logic [OW-1:0]   fu_op;
    logic [DW-1:0]   fu_a;
    logic [DW-1:0]   fu_b;
    logic [TW-1:0]   fu_tag;
    logic [OCCW-1:0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clock = ~Clock;

    rs_mult_station #(
        .NUM_ENTRIES (N),
        .DATA_W      (DW),
        .TAG_W       (TW),
        .BASE_TAG    (BT),
        .OP_W        (OW)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_op    (iss_op),
        .iss_vj    (iss_vj),
        .iss_vk    (iss_vk),
        .iss_qj    (iss_qj),
        .iss_qk    (iss_qk),
        .iss_tag   (iss_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .fu_valid  (fu_valid),
        .fu_ready  (fu_ready),
        .fu_op     (fu_op),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_tag    (fu_tag),
        .occupancy (occupancy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a list of slots with an issue sequence number for age.
    bit m_busy [N];
    int m_op [N];
    int m_vj [N];
    int m_vk [N];
    int m_qj [N];
    int m_qk [N];
    int m_seq [N];
    bit m_lock;
    int m_lidx;
    int m_cnt;

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        m_lock = 0;
        m_lidx = 0;
    endtask

    function automatic int m_pick();
        int best;
        best = -1;
        if (m_lock) return m_lidx;
        for (int i = 0; i < N; i++)
            if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && (best < 0 || m_seq[i] < m_seq[best]))
                best = i;
        return best;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic int m_occ();
        int c;
        c = 0;
        for (int i = 0; i < N; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    task automatic m_step(input int iv, input int op, input int vj, input int vk, input int qj,
                          input int qk, input int cv, input int ct, input int cd, input int fr,
                          input int fl);
        int sel;
        int fi;
        sel = m_pick();
        fi  = m_free();
        if (fl != 0) begin
            m_reset();
            return;
        end
        if (cv != 0 && ct != 0) begin
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && ct != BT + i) begin
                    if (m_qj[i] == ct) begin m_vj[i] = cd; m_qj[i] = 0; end
                    if (m_qk[i] == ct) begin m_vk[i] = cd; m_qk[i] = 0; end
                end
            end
        end
        if (sel >= 0 && fr != 0) begin
            m_busy[sel] = 0;
            m_lock = 0;
        end else if (sel >= 0) begin
            m_lock = 1;
            m_lidx = sel;
        end
        if (iv != 0 && fi >= 0) begin
            m_busy[fi] = 1;
            m_op[fi]   = op;
            m_seq[fi]  = m_cnt;
            m_cnt++;
            if (cv != 0 && ct != 0 && qj == ct) begin m_vj[fi] = cd; m_qj[fi] = 0; end
            else begin m_vj[fi] = vj; m_qj[fi] = qj; end
            if (cv != 0 && ct != 0 && qk == ct) begin m_vk[fi] = cd; m_qk[fi] = 0; end
            else begin m_vk[fi] = vk; m_qk[fi] = qk; end
        end
    endtask

    task automatic check_model(input string tag);
        int sel;
        int fi;
        sel = m_pick();
        fi  = m_free();
        chk({tag, ".fu_valid"}, int'(fu_valid), (sel >= 0) ? 1 : 0);
        if (sel >= 0) begin
            chk({tag, ".fu_op"},  int'(fu_op),  m_op[sel]);
            chk({tag, ".fu_a"},   int'(fu_a),   m_vj[sel]);
            chk({tag, ".fu_b"},   int'(fu_b),   m_vk[sel]);
            chk({tag, ".fu_tag"}, int'(fu_tag), BT + sel);
        end
        chk({tag, ".iss_ready"}, int'(iss_ready), (fi >= 0) ? 1 : 0);
        if (fi >= 0) chk({tag, ".iss_tag"}, int'(iss_tag), BT + fi);
        chk({tag, ".occupancy"}, int'(occupancy), m_occ());
    endtask

    // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
    task automatic cyc(input int iv, input int op, input int vj, input int vk, input int qj,
                       input int qk, input int cv, input int ct, input int cd, input int fr,
                       input int fl);
        iss_valid = (iv != 0);
        iss_op    = OW'(op);
        iss_vj    = DW'(vj);
        iss_vk    = DW'(vk);
        iss_qj    = TW'(qj);
        iss_qk    = TW'(qk);
        cdb_valid = (cv != 0);
        cdb_tag   = TW'(ct);
        cdb_data  = DW'(cd);
        fu_ready  = (fr != 0);
        flush     = (fl != 0);
        m_step(iv, op, vj, vk, qj, qk, cv, ct, cd, fr, fl);
        @(posedge Clock);
        #1;
        iss_valid = 1'b0;
        cdb_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic idle(input int fr);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, fr, 0);
    endtask

    typedef struct {
        int iv, op, vj, vk, qj, qk, cv, ct, cd, fr;
        int ir, it, fv, fa, fb, ft, occ;
    } vec_t;

    function automatic vec_t V(int iv, int op, int vj, int vk, int qj, int qk, int cv, int ct,
                               int cd, int fr, int ir, int it, int fv, int fa, int fb, int ft,
                               int occ);
        vec_t v;
        v.iv = iv; v.op = op; v.vj = vj; v.vk = vk; v.qj = qj; v.qk = qk;
        v.cv = cv; v.ct = ct; v.cd = cd; v.fr = fr;
        v.ir = ir; v.it = it; v.fv = fv; v.fa = fa; v.fb = fb; v.ft = ft; v.occ = occ;
        return v;
    endfunction

    vec_t tab[$];

    initial begin
        // Each row: outputs expected in the current cycle, then inputs for the next edge.
        // iss_tag 0 = not checked (station full); fu data checked only when fu_valid expected.
        tab.push_back(V(1,0,3,5,0,0, 0,0,0,     0,  1,1,0,0,0,0,0));
        tab.push_back(V(0,0,0,0,0,0, 0,0,0,     1,  1,2,1,3,5,1,1));
        tab.push_back(V(1,1,0,2,7,0, 0,0,0,     1,  1,1,0,0,0,0,0));
        tab.push_back(V(1,2,4,0,0,7, 1,7,'hA0,  1,  1,2,0,0,0,0,1));
        tab.push_back(V(0,0,0,0,0,0, 0,0,0,     1,  1,3,1,'hA0,2,1,2));
        tab.push_back(V(0,0,0,0,0,0, 0,0,0,     1,  1,1,1,4,'hA0,2,1));
        tab.push_back(V(1,0,1,1,0,0, 0,0,0,     0,  1,1,0,0,0,0,0));
        tab.push_back(V(1,0,2,2,0,0, 0,0,0,     0,  1,2,1,1,1,1,1));
        tab.push_back(V(1,0,3,3,0,0, 0,0,0,     0,  1,3,1,1,1,1,2));
        tab.push_back(V(1,0,9,9,0,0, 0,0,0,     1,  0,0,1,1,1,1,3));
        tab.push_back(V(1,0,7,8,0,0, 0,0,0,     0,  1,1,1,2,2,2,2));
        tab.push_back(V(0,0,0,0,0,0, 0,0,0,     1,  0,0,1,2,2,2,3));
        tab.push_back(V(0,0,0,0,0,0, 0,0,0,     1,  1,2,1,3,3,3,2));
        tab.push_back(V(0,0,0,0,0,0, 0,0,0,     1,  1,2,1,7,8,1,1));
        tab.push_back(V(1,0,0,6,5,0, 0,0,0,     0,  1,1,0,0,0,0,0));
        tab.push_back(V(1,0,9,10,0,0, 0,0,0,    0,  1,2,0,0,0,0,1));
        tab.push_back(V(0,0,0,0,0,0, 1,5,'h11,  0,  1,3,1,9,10,2,2));
        tab.push_back(V(0,0,0,0,0,0, 0,0,0,     0,  1,3,1,9,10,2,2));
        tab.push_back(V(0,0,0,0,0,0, 0,0,0,     1,  1,3,1,9,10,2,2));
        tab.push_back(V(0,0,0,0,0,0, 0,0,0,     1,  1,2,1,'h11,6,1,1));
        tab.push_back(V(0,0,0,0,0,0, 0,0,0,     0,  1,1,0,0,0,0,0));

        m_reset();
        m_cnt = 0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst.iss_ready", int'(iss_ready), 1);
        chk("rst.iss_tag",   int'(iss_tag),   BT);
        chk("rst.fu_valid",  int'(fu_valid),  0);
        chk("rst.fu_op",     int'(fu_op),     0);
        chk("rst.fu_a",      int'(fu_a),      0);
        chk("rst.fu_b",      int'(fu_b),      0);
        chk("rst.fu_tag",    int'(fu_tag),    0);
        chk("rst.occupancy", int'(occupancy), 0);
        Resetn = 1'b1;

        for (int i = 0; i < tab.size(); i++) begin
            vec_t t;
            t = tab[i];
            chk($sformatf("tab%0d.iss_ready", i), int'(iss_ready), t.ir);
            if (t.it != 0) chk($sformatf("tab%0d.iss_tag", i), int'(iss_tag), t.it);
            chk($sformatf("tab%0d.fu_valid", i), int'(fu_valid), t.fv);
            if (t.fv != 0) begin
                chk($sformatf("tab%0d.fu_a", i),   int'(fu_a),   t.fa);
                chk($sformatf("tab%0d.fu_b", i),   int'(fu_b),   t.fb);
                chk($sformatf("tab%0d.fu_tag", i), int'(fu_tag), t.ft);
            end
            chk($sformatf("tab%0d.occupancy", i), int'(occupancy), t.occ);
            cyc(t.iv, t.op, t.vj, t.vk, t.qj, t.qk, t.cv, t.ct, t.cd, t.fr, 0);
        end

        // Oldest-first: entry 2 is allocated before entry 0; both wake together.
        cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0);
        cyc(1, 2, 0, 2, 6, 0, 0, 0, 0, 0, 0);
        check_model("age.h4");
        chk("age.first_tag", int'(fu_tag), 1);
        idle(1);
        chk("age.reuse_tag", int'(iss_tag), 1);
        cyc(1, 3, 0, 3, 6, 0, 0, 0, 0, 0, 0);
        chk("age.all_waiting", int'(fu_valid), 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 6, 'h66, 0, 0);
        check_model("age.h7");
        chk("age.older_tag", int'(fu_tag), 3);
        chk("age.older_a",   int'(fu_a),   'h66);
        idle(1);
        check_model("age.h8");
        chk("age.younger_tag", int'(fu_tag), 1);
        idle(1);
        chk("age.drained", int'(fu_valid), 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 12, 5, 0, 0);
        check_model("age.h10");
        chk("age.last_tag", int'(fu_tag), 2);
        idle(1);
        chk("age.empty", int'(occupancy), 0);

        // Flush with a full station; dispatch and CDB in the same cycle are discarded.
        for (int i = 0; i < N; i++) cyc(1, 0, i + 1, 2, 0, 0, 0, 0, 0, 0, 0);
        chk("flush.full", int'(occupancy), 3);
        cyc(1, 0, 5, 5, 0, 0, 1, 1, 9, 1, 1);
        chk("flush.occupancy", int'(occupancy), 0);
        chk("flush.fu_valid",  int'(fu_valid),  0);
        chk("flush.iss_ready", int'(iss_ready), 1);
        chk("flush.iss_tag",   int'(iss_tag),   BT);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            chk("flush.no_dispatch", int'(fu_valid), 0);
        end

        // Asynchronous reset mid-operation.
        for (int i = 0; i < N; i++) cyc(1, 1, 7, i + 3, 0, 0, 0, 0, 0, 0, 0);
        chk("arst.full", int'(occupancy), 3);
        Resetn = 1'b0;
        #1;
        chk("arst.occupancy", int'(occupancy), 0);
        chk("arst.fu_valid",  int'(fu_valid),  0);
        chk("arst.fu_a",      int'(fu_a),      0);
        chk("arst.fu_tag",    int'(fu_tag),    0);
        chk("arst.iss_ready", int'(iss_ready), 1);
        chk("arst.iss_tag",   int'(iss_tag),   BT);
        m_reset();
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle(1);
            chk("arst.no_dispatch", int'(fu_valid), 0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int iv, op, vj, vk, qj, qk, cv, ct, cd, fr, fl, at;
            check_model($sformatf("rnd%0d", c));
            at = BT + m_free();
            iv = ($urandom_range(0, 2) != 0) ? 1 : 0;
            op = int'($urandom_range(0, 3));
            vj = int'($urandom_range(0, 65535));
            vk = int'($urandom_range(0, 65535));
            qj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : 0;
            qk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : 0;
            if (qj == at) qj = 0;
            if (qk == at) qk = 0;
            cv = int'($urandom_range(0, 1));
            ct = int'($urandom_range(0, 9));
            cd = int'($urandom_range(0, 65535));
            fr = ($urandom_range(0, 3) != 0) ? 1 : 0;
            fl = ($urandom_range(0, 149) == 0) ? 1 : 0;
            cyc(iv, op, vj, vk, qj, qk, cv, ct, cd, fr, fl);
        end
        check_model("rnd.end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
